bg_phase_decoder: RTL and testbench
===================================

BG_PHASE_DECODER -- requirements
Module: bg_phase_decoder

Interface
REQ-001 SHALL have parameter LOCK_TOGGLES, default 4: number of consecutive alternating decisions required to declare lock (legal range 2..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of settle_cnt.
REQ-003 SHALL have input clk, 1 bit: rising-edge clock, the same clock as the bandgap switch controller.
REQ-004 SHALL have input reset, 1 bit: asynchronous, active-high.
REQ-005 SHALL have input cmp, 1 bit: comparator output, already synchronous to clk.
REQ-006 SHALL have inputs pi1, pi2, pii1, pii2, 1 bit each: diode and big-diode switch phases from the controller.
REQ-007 SHALL have inputs pa, pb, pc, pd, 1 bit each: capacitor charge and output switch phases.
REQ-008 SHALL have input setup_bias, 1 bit: controller bias-setup indication; high holds the decoder in IDLE.
REQ-009 SHALL have output phase, 3 bits: registered decoded phase code.
REQ-010 SHALL have output phase_err, 1 bit: sticky flag for an illegal switch combination.
REQ-011 SHALL have output smp_stb, 1 bit: one-cycle strobe marking a new comparator sample.
REQ-012 SHALL have output cmp_smp, 1 bit: the latched comparator sample.
REQ-013 SHALL have outputs up and dn, 1 bit each: one-cycle trim-decision pulses.
REQ-014 SHALL have output lock, 1 bit: high while the loop is locked.
REQ-015 SHALL have output lock_lost, 1 bit: sticky flag set on any loss of lock.
REQ-016 SHALL have output valid, 1 bit: the bandgap output is usable.
REQ-017 SHALL have output settle_cnt, CNT_W bits: number of samples taken since setup_bias fell.

Function
REQ-018 SHALL register phase each cycle from the current switch inputs, using the following codes (first match wins):
- 7 ILLEGAL: (pi1|pi2)&(pii1|pii2), or pa&(pi1|pi2|pii1|pii2).
- 1 DIODE: pii1&pii2.
- 2 BIGDIODE: pi1&pi2.
- 3 CHARGE_H: pa&pb&!pc.
- 4 CHARGE_L: pa&pc&!pb.
- 5 OUTPUT: pb&pc&pd&!pa.
- 6 BLANK: exactly one of pi1 or pii1 high, with its partner pi2 or pii2 low.
- 0 IDLE: all other combinations, including all-low.
REQ-019 SHALL set phase_err one cycle after a code-7 input and hold it high until reset.
REQ-020 SHALL detect the falling edge of pi2 using a registered copy of pi2.
REQ-021 On a pi2 falling edge, SHALL capture cmp into cmp_smp and pulse smp_stb high for exactly one cycle, with 1-cycle latency from the edge.
REQ-022 SHALL generate no strobe when pi2 is high during reset release.
REQ-023 SHALL implement a decision FSM with states IDLE, TRACK and LOCKED.
REQ-024 IDLE -> TRACK on the first cycle with setup_bias=0; on that transition settle_cnt clears to 0, toggle_cnt clears to 0, and the previous decision becomes invalid.
REQ-025 In TRACK or LOCKED, each smp_stb SHALL be followed one cycle later by up=1 if cmp_smp=1, else dn=1; up and dn SHALL never be high together.
REQ-026 toggle_cnt (4 bits):
- increments when a decision differs from the previous valid decision;
- is set to 0 when the decision equals it;
- is left at 0 on the first decision, which only becomes the previous decision.
REQ-027 TRACK -> LOCKED when toggle_cnt reaches LOCK_TOGGLES; lock=1 in the same cycle as the state change.
REQ-028 LOCKED -> TRACK on two consecutive equal decisions; lock=0 and lock_lost=1 (sticky) from that cycle.
REQ-029 setup_bias=1 in any state SHALL force IDLE next cycle and clear lock, toggle_cnt and valid; it SHALL NOT clear lock_lost or phase_err.
REQ-030 settle_cnt SHALL increment on each smp_stb in TRACK or LOCKED and saturate at 2^CNT_W-1 without wrapping.
REQ-031 valid SHALL be registered as lock & (phase==5) & !phase_err.
REQ-032 If smp_stb coincides with setup_bias=1, the sample SHALL be latched into cmp_smp but no decision SHALL be produced and settle_cnt SHALL NOT change.

Reset
REQ-033 While reset is high, all of the following SHALL be 0: phase, phase_err, smp_stb, cmp_smp, up, dn, lock, lock_lost, valid, settle_cnt, toggle_cnt, the pi2 history register, and the previous-decision valid flag.
REQ-034 The FSM SHALL be in IDLE while reset is high, and reset SHALL take effect immediately in any state, including mid-strobe.
REQ-035 The first active clock edge after reset deassertion SHALL only register inputs; no strobe or decision SHALL occur on it.

Verification
REQ-036 Scenario: pii1=pii2=1 then pi1=pi2=1 -> phase=1 then phase=2 one cycle after each input change; phase_err stays 0.
REQ-037 Scenario: pi1=1 and pii1=1 for one cycle -> phase=7 and phase_err=1, and phase_err remains 1 after 100 clean cycles.
REQ-038 Scenario: setup_bias=0, pi2 pulses with cmp alternating 1,0,1,0,1 at LOCK_TOGGLES=4 -> up,dn,up,dn,up pulses, lock=1 after the fifth decision, and settle_cnt=5.
REQ-039 Scenario: while locked, apply two pi2 pulses with cmp=0 -> lock falls after the second dn and lock_lost=1.
REQ-040 Scenario: locked and pb=pc=pd=1 with pa=0 -> valid=1 two cycles after the phase change; then raise setup_bias -> valid=0 and lock=0 next cycle while lock_lost is unchanged.
REQ-041 Scenario: assert reset mid-TRACK with settle_cnt=3, CNT_W=2 saturation pre-tested at 3 -> all outputs 0 immediately; release and apply one pi2 pulse with setup_bias=0 -> the first decision raises no toggle and settle_cnt=1.

Source files
------------

// File: rtl/bg_phase_decoder.sv
// Bandgap switch-phase decoder: classifies controller switch phases, samples the
// comparator on the pi2 falling edge and runs the up/dn trim decision and lock FSM.
module bg_phase_decoder #(
  parameter int LOCK_TOGGLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp,
  input  logic             pi1,
  input  logic             pi2,
  input  logic             pii1,
  input  logic             pii2,
  input  logic             pa,
  input  logic             pb,
  input  logic             pc,
  input  logic             pd,
  input  logic             setup_bias,
  output logic [2:0]       phase,
  output logic             phase_err,
  output logic             smp_stb,
  output logic             cmp_smp,
  output logic             up,
  output logic             dn,
  output logic             lock,
  output logic             lock_lost,
  output logic             valid,
  output logic [CNT_W-1:0] settle_cnt
);

  localparam logic [2:0] PH_IDLE     = 3'd0;
  localparam logic [2:0] PH_DIODE    = 3'd1;
  localparam logic [2:0] PH_BIGDIODE = 3'd2;
  localparam logic [2:0] PH_CHARGE_H = 3'd3;
  localparam logic [2:0] PH_CHARGE_L = 3'd4;
  localparam logic [2:0] PH_OUTPUT   = 3'd5;
  localparam logic [2:0] PH_BLANK    = 3'd6;
  localparam logic [2:0] PH_ILLEGAL  = 3'd7;

  localparam logic [3:0]       LOCK_T  = 4'(LOCK_TOGGLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_LOCKED
  } state_t;

  state_t     state, state_next;
  logic [2:0] phase_d;
  logic       pi2_q;
  logic [3:0] toggle_cnt, tog_new;
  logic       prev_vld, prev_dec;
  logic       dec_en, same;

  // Phase classification, first match wins.
  always_comb begin
    phase_d = PH_IDLE;
    if (((pi1 | pi2) & (pii1 | pii2)) | (pa & (pi1 | pi2 | pii1 | pii2)))
      phase_d = PH_ILLEGAL;
    else if (pii1 & pii2)
      phase_d = PH_DIODE;
    else if (pi1 & pi2)
      phase_d = PH_BIGDIODE;
    else if (pa & pb & ~pc)
      phase_d = PH_CHARGE_H;
    else if (pa & pc & ~pb)
      phase_d = PH_CHARGE_L;
    else if (pb & pc & pd & ~pa)
      phase_d = PH_OUTPUT;
    else if ((pi1 & ~pii1 & ~pi2) | (pii1 & ~pi1 & ~pii2))
      phase_d = PH_BLANK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= PH_IDLE;
      phase_err <= 1'b0;
    end else begin
      phase     <= phase_d;
      phase_err <= phase_err | (phase_d == PH_ILLEGAL);
    end
  end

  // pi2_q resets low so a pi2 held high through reset release cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pi2_q   <= 1'b0;
      smp_stb <= 1'b0;
      cmp_smp <= 1'b0;
    end else begin
      pi2_q   <= pi2;
      smp_stb <= pi2_q & ~pi2;
      if (pi2_q & ~pi2)
        cmp_smp <= cmp;
    end
  end

  // A strobe seen while setup_bias is high still latches cmp_smp but is not a decision.
  always_comb begin
    dec_en = smp_stb & ~setup_bias & (state != S_IDLE);
    same   = prev_vld & (cmp_smp == prev_dec);
    if (!prev_vld || same)
      tog_new = 4'd0;
    else if (toggle_cnt == 4'hf)
      tog_new = toggle_cnt;
    else
      tog_new = toggle_cnt + 4'd1;
  end

  always_comb begin
    state_next = state;
    if (setup_bias) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_next = S_TRACK;
        S_TRACK:  if (dec_en && tog_new >= LOCK_T) state_next = S_LOCKED;
        S_LOCKED: if (dec_en && same) state_next = S_TRACK;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up         <= 1'b0;
      dn         <= 1'b0;
      lock       <= 1'b0;
      lock_lost  <= 1'b0;
      toggle_cnt <= 4'd0;
      prev_vld   <= 1'b0;
      prev_dec   <= 1'b0;
      settle_cnt <= '0;
    end else begin
      up        <= dec_en & cmp_smp;
      dn        <= dec_en & ~cmp_smp;
      lock      <= (state_next == S_LOCKED);
      lock_lost <= lock_lost | ((state == S_LOCKED) && (state_next == S_TRACK));

      if (setup_bias || state == S_IDLE) begin
        toggle_cnt <= 4'd0;
        prev_vld   <= 1'b0;
      end else if (dec_en) begin
        toggle_cnt <= tog_new;
        prev_vld   <= 1'b1;
        prev_dec   <= cmp_smp;
      end

      // Leaving IDLE restarts the settle count; it then saturates rather than wraps.
      if (state == S_IDLE && !setup_bias)
        settle_cnt <= '0;
      else if (dec_en && settle_cnt != CNT_MAX)
        settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      valid <= 1'b0;
    else if (setup_bias)
      valid <= 1'b0;
    else
      valid <= lock & (phase == PH_OUTPUT) & ~phase_err;
  end

endmodule

// File: tb/tb_bg_phase_decoder.sv
// Self-checking bench for bg_phase_decoder: phase decode table, scoreboarded
// up/dn decisions, lock/valid behaviour, and a CNT_W=2 instance for saturation.
module tb_bg_phase_decoder;
  logic clk = 1'b0;
  logic reset, cmp, pi1, pi2, pii1, pii2, pa, pb, pc, pd, setup_bias;
  logic [2:0] phase;
  logic phase_err, smp_stb, cmp_smp, up, dn, lock, lock_lost, valid;
  logic [7:0] settle_cnt;
  logic [2:0] phase2;
  logic phase_err2, smp_stb2, cmp_smp2, up2, dn2, lock2, lock_lost2, valid2;
  logic [1:0] settle_cnt2;

  int nchk = 0;
  int nerr = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  bg_phase_decoder #(.LOCK_TOGGLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .cmp(cmp), .pi1(pi1), .pi2(pi2), .pii1(pii1), .pii2(pii2),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .setup_bias(setup_bias),
    .phase(phase), .phase_err(phase_err), .smp_stb(smp_stb), .cmp_smp(cmp_smp),
    .up(up), .dn(dn), .lock(lock), .lock_lost(lock_lost), .valid(valid),
    .settle_cnt(settle_cnt));

  bg_phase_decoder #(.LOCK_TOGGLES(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .cmp(cmp), .pi1(pi1), .pi2(pi2), .pii1(pii1), .pii2(pii2),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .setup_bias(setup_bias),
    .phase(phase2), .phase_err(phase_err2), .smp_stb(smp_stb2), .cmp_smp(cmp_smp2),
    .up(up2), .dn(dn2), .lock(lock2), .lock_lost(lock_lost2), .valid(valid2),
    .settle_cnt(settle_cnt2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Decision monitor: every up/dn pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (up || dn)) begin
      if (exp_q.size() == 0)
        chk("unexp_dec", {30'd0, up, dn}, 32'd0);
      else
        chk("decision", {30'd0, up, dn}, exp_q.pop_front() ? 32'd2 : 32'd1);
    end
  end

  task automatic pulse(input logic c, input bit expect_dec);
    @(negedge clk); cmp = c; pi2 = 1'b1;
    @(negedge clk); pi2 = 1'b0;
    if (expect_dec) exp_q.push_back(c);
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_sw(input logic [7:0] v);
    {pi1, pi2, pii1, pii2, pa, pb, pc, pd} = v;
  endtask

  logic [7:0] sw_tab [11] = '{8'b0011_0000, 8'b1100_0000, 8'b0000_1100, 8'b0000_1010,
                              8'b0000_0111, 8'b1000_0000, 8'b0010_0000, 8'b0000_0000,
                              8'b0000_1110, 8'b1010_0000, 8'b1000_1000};
  logic [2:0] ph_tab [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0, 3'd7, 3'd7};

  initial begin
    reset = 1'b1; setup_bias = 1'b1; cmp = 1'b0;
    drive_sw(8'h00);
    #1;
    chk("rst_state", {13'd0, phase, phase_err, smp_stb, cmp_smp, up, dn, lock, lock_lost,
                      valid, settle_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Phase decode table; the first nine entries are legal.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); drive_sw(sw_tab[i]);
      @(negedge clk); chk($sformatf("phase[%0d]", i), {29'd0, phase}, {29'd0, ph_tab[i]});
      if (i == 8) chk("err_clean", {31'd0, phase_err}, 32'd0);
      if (i == 9) chk("err_set", {31'd0, phase_err}, 32'd1);
    end
    drive_sw(8'h00);
    repeat (100) @(negedge clk);
    chk("err_sticky", {28'd0, phase, phase_err}, 32'd1);

    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("err_rst", {31'd0, phase_err}, 32'd0);

    // Alternating decisions up to lock.
    setup_bias = 1'b0;
    repeat (2) @(negedge clk);
    pulse(1'b1, 1); pulse(1'b0, 1); pulse(1'b1, 1); pulse(1'b0, 1);
    chk("no_lock_4", {31'd0, lock}, 32'd0);
    pulse(1'b1, 1);
    chk("lock_5", {30'd0, lock, lock_lost}, 32'd2);
    chk("settle_5", {24'd0, settle_cnt}, 32'd5);
    chk("settle_sat", {30'd0, settle_cnt2}, 32'd3);

    // Two equal decisions drop lock.
    pulse(1'b0, 1);
    chk("lock_hold", {31'd0, lock}, 32'd1);
    pulse(1'b0, 1);
    chk("lock_drop", {30'd0, lock, lock_lost}, 32'd1);

    pulse(1'b1, 1); pulse(1'b0, 1); pulse(1'b1, 1); pulse(1'b0, 1);
    chk("relock", {31'd0, lock}, 32'd1);

    // Output phase while locked gives valid two cycles later.
    @(negedge clk); drive_sw(8'b0000_0111);
    @(negedge clk); chk("ph_out", {28'd0, phase, valid}, {28'd0, 3'd5, 1'b0});
    @(negedge clk); chk("valid_on", {31'd0, valid}, 32'd1);

    // Strobe coinciding with setup_bias: latched, but no decision or count.
    @(negedge clk); cmp = 1'b1; pi2 = 1'b1;
    @(negedge clk); pi2 = 1'b0;
    @(negedge clk); setup_bias = 1'b1;
    chk("stb_coinc", {31'd0, smp_stb}, 32'd1);
    @(negedge clk);
    chk("bias_drop", {29'd0, valid, lock, lock_lost}, 32'd1);
    chk("bias_smp", {31'd0, cmp_smp}, 32'd1);
    chk("bias_settle", {24'd0, settle_cnt}, 32'd11);
    repeat (2) @(negedge clk);

    // Reset mid-TRACK while a strobe is in flight.
    setup_bias = 1'b0;
    repeat (2) @(negedge clk);
    pulse(1'b1, 1); pulse(1'b1, 1); pulse(1'b0, 1);
    chk("settle_3", {22'd0, settle_cnt, settle_cnt2}, {22'd0, 8'd3, 2'd3});
    @(negedge clk); cmp = 1'b1; pi2 = 1'b1;
    @(negedge clk); pi2 = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_stb", {31'd0, smp_stb}, 32'd1);
    pi2 = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_async", {13'd0, phase, phase_err, smp_stb, cmp_smp, up, dn, lock, lock_lost,
                      valid, settle_cnt}, 32'd0);
    @(negedge clk); reset = 1'b0; cmp = 1'b0;
    @(negedge clk); chk("rel_no_stb0", {31'd0, smp_stb}, 32'd0);
    @(negedge clk); chk("rel_no_stb1", {31'd0, smp_stb}, 32'd0);
    pulse(1'b0, 1);
    chk("post_rst", {22'd0, lock, settle_cnt, 1'b0}, {22'd0, 1'b0, 8'd1, 1'b0});
    chk("post_rst2", {30'd0, settle_cnt2}, 32'd1);

    repeat (4) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
